// File: rtl/uart_receiver.sv
// 8-bit UART receiver with a one-byte output buffer, error flags and sticky overrun.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart_receiver #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       rx,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       parity_error,
  output logic       framing_error,
  output logic       overrun
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd3;
`endif
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;

  localparam logic [15:0] HALF_BIT = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL_BIT = 16'(CLK_DIV - 1);

  logic        sync1_q, sync2_q;
  logic [2:0]  state_q, state_d;
  logic [15:0] tick_q, tick_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        frame_done, expired, handshake, accept_new;
  logic        valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic [7:0]  data_q, data_d;
  logic        rx_sync;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
`endif

  assign rx_sync = sync2_q;
  assign expired = (tick_q == 16'd0);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_sync) begin
          state_d = START;
          tick_d  = HALF_BIT;
        end
      end
      START: begin
        if (!expired) begin
          tick_d = tick_q - 16'd1;
        end else if (rx_sync) begin
          state_d = IDLE;  // start bit did not survive to mid-bit: glitch
        end else begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
          tick_d    = FULL_BIT;
        end
      end
      DATA: begin
        if (!expired) begin
          tick_d = tick_q - 16'd1;
        end else begin
          shift_d[bit_cnt_q] = rx_sync;
          tick_d             = FULL_BIT;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!expired) begin
          tick_d = tick_q - 16'd1;
        end else begin
          par_d   = rx_sync;
          tick_d  = FULL_BIT;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (!expired) begin
          tick_d = tick_q - 16'd1;
        end else begin
          frame_done = 1'b1;
          state_d    = rx_sync ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rx_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A finished frame is kept only if the buffer is empty or being drained this cycle.
  assign handshake  = valid_q & out_ready;
  assign accept_new = frame_done & (~valid_q | handshake);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    if (accept_new) begin
      valid_d = 1'b1;
      data_d  = shift_q;
      ferr_d  = ~rx_sync;
`ifdef UART_RX_PARITY_EN
      perr_d  = (^shift_q) ^ par_q;
`endif
    end else if (handshake) begin
      valid_d = 1'b0;
    end
    if (frame_done && valid_q && !handshake) begin
      ovr_d = 1'b1;
    end else if (handshake) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      tick_q    <= 16'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      valid_q   <= 1'b0;
      data_q    <= 8'd0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign out_valid     = valid_q;
  assign out_data      = data_q;
  assign framing_error = ferr_q;
  assign overrun       = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error  = perr_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: stimulus pushes expected bytes, a monitor pops on handshake.
// Follows UART_RX_PARITY_EN to decide whether a parity bit is sent.
module tb_uart_receiver;

  localparam int unsigned DIV = 4;
`ifdef UART_RX_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nreset, rx, out_ready;
  logic       out_valid, parity_error, framing_error, overrun;
  logic [7:0] out_data;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t sb[$];

  uart_receiver #(.CLK_DIV(DIV)) dut (
    .clk           (clk),
    .nreset        (nreset),
    .rx            (rx),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted byte must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (nreset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte actual=%0h required=none", out_data);
      end else begin
        e = sb.pop_front();
        check("byte_data", {24'd0, out_data}, {24'd0, e.data});
        check("byte_parity_error", {31'd0, parity_error}, {31'd0, e.perr});
        check("byte_framing_error", {31'd0, framing_error}, {31'd0, e.ferr});
        check("byte_overrun", {31'd0, overrun}, {31'd0, e.ovr});
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    cycles(DIV);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    if (ParEn) bit_out((^d) ^ flip);
    bit_out(stop);
    rx = 1'b1;
  endtask

  task automatic send_expect(input logic [7:0] d, input logic flip, input logic stop);
    exp_t e;
    e.data = d;
    e.perr = ParEn & flip;
    e.ferr = ~stop;
    e.ovr  = 1'b0;
    sb.push_back(e);
    send_frame(d, flip, stop);
  endtask

  initial begin
    exp_t e;
    int   waited;
    rx        = 1'b1;
    nreset    = 1'b0;
    out_ready = 1'b1;
    cycles(3);
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", {24'd0, out_data}, 32'd0);
    check("reset_parity_error", {31'd0, parity_error}, 32'd0);
    check("reset_framing_error", {31'd0, framing_error}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    cycles(5);

    // Clean frame
    send_expect(8'h5A, 1'b0, 1'b1);
    cycles(2 * DIV);

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit
    send_expect(8'h01, 1'b1, 1'b1);
    cycles(2 * DIV);
`endif

    // Stop bit low, line stuck low afterwards: only one frame may appear
    send_expect(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    cycles(20);
    rx = 1'b1;
    cycles(3 * DIV);

    // One-clock glitch in idle
    rx = 1'b0;
    cycles(1);
    rx = 1'b1;
    cycles(3 * DIV);
    send_expect(8'hA5, 1'b0, 1'b1);
    cycles(2 * DIV);

    // Overrun: second frame dropped while the first waits
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    cycles(2 * DIV);
    send_frame(8'h22, 1'b0, 1'b1);
    cycles(2 * DIV);
    @(negedge clk);
    check("ovr_held_valid", {31'd0, out_valid}, 32'd1);
    check("ovr_held_data", {24'd0, out_data}, 32'h11);
    check("ovr_flag_set", {31'd0, overrun}, 32'd1);
    e = '{data: 8'h11, perr: 1'b0, ferr: 1'b0, ovr: 1'b1};
    sb.push_back(e);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_after_valid", {31'd0, out_valid}, 32'd0);
    check("ovr_after_flag", {31'd0, overrun}, 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-frame, with an unaccepted byte sitting in the buffer
    out_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1);
    cycles(2 * DIV);
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b1);
    rx = 1'b1;
    cycles(2);
    @(negedge clk);
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    nreset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_out_data", {24'd0, out_data}, 32'd0);
    check("midreset_parity_error", {31'd0, parity_error}, 32'd0);
    check("midreset_framing_error", {31'd0, framing_error}, 32'd0);
    check("midreset_overrun", {31'd0, overrun}, 32'd0);
    @(posedge clk);
    #1;
    nreset    = 1'b1;
    out_ready = 1'b1;
    cycles(10 * DIV);
    send_expect(8'h80, 1'b0, 1'b1);

    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      cycles(1);
      waited++;
    end
    cycles(4 * DIV);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
